// File: rtl/qlearn_pkg.sv
// Shared types and constants for the Q-learning update datapath.
package qlearn_pkg;

    localparam int Q_W     = 16;
    localparam int STATE_W = 5;
    localparam int ACT_W   = 2;
    localparam int ADDR_W  = STATE_W + ACT_W;
    localparam int ITER_W  = 12;
    localparam int STEP_W  = 4;

    localparam logic [STATE_W-1:0] TERMINAL    = 5'd25;
    localparam logic [STATE_W-1:0] START_STATE = 5'd0;
    localparam logic [STEP_W-1:0]  MAX_STEPS   = 4'd15;
    localparam logic [STEP_W-1:0]  LAST_STEP   = MAX_STEPS - 4'd1;

    // Step sequencer states
    typedef enum logic [2:0] {
        IDLE,
        ACT,
        RD_Q,
        RD_MAX,
        ALU,
        WR,
        ADV,
        DONE
    } seq_state_t;

    // Q-table address is the state index concatenated with the action index
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [STATE_W-1:0] state,
                                                    input logic [ACT_W-1:0]   action);
        return {state, action};
    endfunction

endpackage

// File: rtl/max_q_tracker.sv
// Signed running-maximum register. Strictly-greater update keeps the
// earliest (lowest action index) value on ties.
module max_q_tracker
    import qlearn_pkg::*;
#(
    parameter int W = Q_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         update,
    input  logic [W-1:0] din,
    output logic [W-1:0] max_val
);

    // Clear has priority, load seeds the max, update keeps the larger signed value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_val <= '0;
        end else if (clear) begin
            max_val <= '0;
        end else if (load) begin
            max_val <= din;
        end else if (update && ($signed(din) > $signed(max_val))) begin
            max_val <= din;
        end
    end

endmodule

// File: rtl/q_update_sequencer.sv
// Step-level controller: action fetch, Q(s,a) and max Q(s',.) reads,
// update-ALU trigger and write-back, plus step/episode bookkeeping.
module q_update_sequencer
    import qlearn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ITER_W-1:0]   total_iteration_in,
    output logic                act_req,
    input  logic                act_valid,
    input  logic [ACT_W-1:0]    action_in,
    input  logic [STATE_W-1:0]  next_state_in,
    output logic                q_rd_en,
    output logic [ADDR_W-1:0]   q_rd_addr,
    input  logic [Q_W-1:0]      q_rd_data,
    output logic [Q_W-1:0]      q_sa,
    output logic [Q_W-1:0]      max_q,
    output logic                alu_start,
    input  logic                alu_done,
    output logic                q_wr_en,
    output logic [ADDR_W-1:0]   q_wr_addr,
    output logic [STATE_W-1:0]  cur_state,
    output logic [ACT_W-1:0]    cur_action,
    output logic [STEP_W-1:0]   step,
    output logic [ITER_W-1:0]   iteration,
    output logic                busy,
    output logic                done
);

    seq_state_t          fsm_state;
    seq_state_t          fsm_next;
    logic [ITER_W-1:0]   total;
    logic [STATE_W-1:0]  env_next;
    logic [2:0]          rd_cnt;
    logic                alu_fired;
    logic                trk_clear;
    logic                trk_load;
    logic                trk_update;
    logic                next_is_term;
    logic                episode_end;
    logic [ITER_W-1:0]   iteration_inc;

    assign next_is_term  = (env_next == TERMINAL);
    assign episode_end   = next_is_term || (step == LAST_STEP);
    assign iteration_inc = iteration + ITER_W'(1);
    assign q_wr_addr     = pack_addr(cur_state, cur_action);
    assign busy          = (fsm_state != IDLE) && (fsm_state != DONE);
    assign done          = (fsm_state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_state <= IDLE;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        fsm_next   = fsm_state;
        act_req    = 1'b0;
        q_rd_en    = 1'b0;
        q_rd_addr  = '0;
        alu_start  = 1'b0;
        q_wr_en    = 1'b0;
        trk_clear  = 1'b0;
        trk_load   = 1'b0;
        trk_update = 1'b0;
        case (fsm_state)
            IDLE, DONE: begin
                if (start) begin
                    fsm_next = (total_iteration_in == '0) ? DONE : ACT;
                end
            end
            ACT: begin
                act_req = 1'b1;
                if (act_valid) begin
                    fsm_next = RD_Q;
                end
            end
            RD_Q: begin
                q_rd_en   = 1'b1;
                q_rd_addr = pack_addr(cur_state, cur_action);
                fsm_next  = RD_MAX;
            end
            RD_MAX: begin
                if (next_is_term) begin
                    trk_clear = 1'b1;
                    fsm_next  = ALU;
                end else begin
                    if (rd_cnt < 3'd4) begin
                        q_rd_en   = 1'b1;
                        q_rd_addr = pack_addr(env_next, rd_cnt[1:0]);
                    end
                    trk_load   = (rd_cnt == 3'd1);
                    trk_update = (rd_cnt >= 3'd2);
                    if (rd_cnt == 3'd4) begin
                        fsm_next = ALU;
                    end
                end
            end
            ALU: begin
                alu_start = !alu_fired;
                if (alu_done) begin
                    fsm_next = WR;
                end
            end
            WR: begin
                q_wr_en  = 1'b1;
                fsm_next = ADV;
            end
            ADV: begin
                if (episode_end && (iteration_inc == total)) begin
                    fsm_next = DONE;
                end else begin
                    fsm_next = ACT;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // Step datapath: run setup, action latch, read capture and step/episode counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total      <= '0;
            cur_state  <= '0;
            cur_action <= '0;
            env_next   <= '0;
            step       <= '0;
            iteration  <= '0;
            rd_cnt     <= '0;
            q_sa       <= '0;
            alu_fired  <= 1'b0;
        end else begin
            alu_fired <= (fsm_state == ALU);
            case (fsm_state)
                IDLE, DONE: begin
                    if (start) begin
                        total     <= total_iteration_in;
                        cur_state <= START_STATE;
                        step      <= '0;
                        iteration <= '0;
                    end
                end
                ACT: begin
                    if (act_valid) begin
                        cur_action <= action_in;
                        env_next   <= next_state_in;
                    end
                end
                RD_Q: begin
                    rd_cnt <= '0;
                end
                RD_MAX: begin
                    if (rd_cnt == 3'd0) begin
                        q_sa <= q_rd_data;
                    end
                    rd_cnt <= rd_cnt + 3'd1;
                end
                ADV: begin
                    if (episode_end) begin
                        iteration <= iteration_inc;
                        step      <= '0;
                        cur_state <= START_STATE;
                    end else begin
                        step      <= step + 4'd1;
                        cur_state <= env_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    max_q_tracker #(.W(Q_W)) u_max_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (trk_clear),
        .load    (trk_load),
        .update  (trk_update),
        .din     (q_rd_data),
        .max_val (max_q)
    );

endmodule

// File: tb/tb_q_update_sequencer.sv
// Self-checking bench for q_update_sequencer: randomized environment, Q-memory
// and ALU responders feed a scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_q_update_sequencer;
    import qlearn_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [ITER_W-1:0]   total_iteration_in = '0;
    logic                act_req;
    logic                act_valid = 1'b0;
    logic [ACT_W-1:0]    action_in = '0;
    logic [STATE_W-1:0]  next_state_in = '0;
    logic                q_rd_en;
    logic [ADDR_W-1:0]   q_rd_addr;
    logic [Q_W-1:0]      q_rd_data = '0;
    logic [Q_W-1:0]      q_sa;
    logic [Q_W-1:0]      max_q;
    logic                alu_start;
    logic                alu_done = 1'b0;
    logic                q_wr_en;
    logic [ADDR_W-1:0]   q_wr_addr;
    logic [STATE_W-1:0]  cur_state;
    logic [ACT_W-1:0]    cur_action;
    logic [STEP_W-1:0]   step;
    logic [ITER_W-1:0]   iteration;
    logic                busy;
    logic                done;

    q_update_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .total_iteration_in (total_iteration_in),
        .act_req            (act_req),
        .act_valid          (act_valid),
        .action_in          (action_in),
        .next_state_in      (next_state_in),
        .q_rd_en            (q_rd_en),
        .q_rd_addr          (q_rd_addr),
        .q_rd_data          (q_rd_data),
        .q_sa               (q_sa),
        .max_q              (max_q),
        .alu_start          (alu_start),
        .alu_done           (alu_done),
        .q_wr_en            (q_wr_en),
        .q_wr_addr          (q_wr_addr),
        .cur_state          (cur_state),
        .cur_action         (cur_action),
        .step               (step),
        .iteration          (iteration),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0]     addr;
        logic signed [Q_W-1:0] q_sa;
        logic signed [Q_W-1:0] max_q;
        logic [STEP_W-1:0]     step;
        logic [ITER_W-1:0]     iter;
        int                    accept_cyc;
        int                    lat;
    } wr_exp_t;

    typedef struct {
        logic [ACT_W-1:0]   a;
        logic [STATE_W-1:0] ns;
    } forced_t;

    wr_exp_t               wr_q[$];
    logic [ADDR_W-1:0]     rd_q[$];
    forced_t               forced_q[$];
    longint                seen_max[$];
    longint                seen_qsa[$];
    logic signed [Q_W-1:0] mem [128];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int reads_seen = 0;
    int writes = 0;
    int act_cycles = 0;
    int alu_starts = 0;
    int alu_delay = 1;
    int term_pct = 0;
    int valid_pct = 100;

    logic [STATE_W-1:0] m_state;
    logic [STEP_W-1:0]  m_step;
    logic [ITER_W-1:0]  m_iter;
    logic [ITER_W-1:0]  m_total;
    bit                 m_done = 1'b1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model of one learning step: expected reads and write, then s/step/episode advance
    task automatic predictStep(input logic [ACT_W-1:0] a, input logic [STATE_W-1:0] ns);
        wr_exp_t               e;
        logic signed [Q_W-1:0] best;
        logic [ADDR_W-1:0]     addr;
        e.addr = {m_state, a};
        e.q_sa = mem[e.addr];
        rd_q.push_back(e.addr);
        if (ns == 5'd25) begin
            e.max_q = '0;
        end else begin
            best = mem[{ns, 2'd0}];
            rd_q.push_back({ns, 2'd0});
            for (int k = 1; k < 4; k++) begin
                addr = {ns, 2'(k)};
                rd_q.push_back(addr);
                if (mem[addr] > best) best = mem[addr];
            end
            e.max_q = best;
        end
        e.step = m_step;
        e.iter = m_iter;
        e.accept_cyc = cyc;
        e.lat = ((ns == 5'd25) ? 4 : 8) + alu_delay;
        wr_q.push_back(e);
        if (ns == 5'd25 || m_step == 4'd14) begin
            m_iter  = m_iter + 1'b1;
            m_step  = '0;
            m_state = '0;
            if (m_iter == m_total) m_done = 1'b1;
        end else begin
            m_step  = m_step + 1'b1;
            m_state = ns;
        end
    endtask

    task automatic applyStimulus(input int total);
        m_state = '0;
        m_step  = '0;
        m_iter  = '0;
        m_total = total[ITER_W-1:0];
        m_done  = (total == 0);
        seen_max.delete();
        seen_qsa.delete();
        total_iteration_in = total[ITER_W-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_done_reached"}, done, 1);
    endtask

    task automatic finalChecks(input string name);
        checkOutput({name, "_iteration"}, iteration, m_total);
        checkOutput({name, "_step"}, step, 0);
        checkOutput({name, "_cur_state"}, cur_state, 0);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_pending_writes"}, wr_q.size(), 0);
        checkOutput({name, "_pending_reads"}, rd_q.size(), 0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_act_req"}, act_req, 0);
        checkOutput({name, "_q_rd_en"}, q_rd_en, 0);
        checkOutput({name, "_q_wr_en"}, q_wr_en, 0);
        checkOutput({name, "_alu_start"}, alu_start, 0);
        checkOutput({name, "_q_sa"}, q_sa, 0);
        checkOutput({name, "_max_q"}, max_q, 0);
        checkOutput({name, "_cur_state"}, cur_state, 0);
        checkOutput({name, "_cur_action"}, cur_action, 0);
        checkOutput({name, "_step"}, step, 0);
        checkOutput({name, "_iteration"}, iteration, 0);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_done"}, done, 0);
        checkOutput({name, "_q_wr_addr"}, q_wr_addr, 0);
    endtask

    task automatic fillMemRandom();
        for (int i = 0; i < 128; i++) mem[i] = Q_W'($urandom);
    endtask

    // Cycle counter used for latency measurement
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Environment/policy responder
    initial begin
        forever_env : forever begin
            forced_t f;
            @(negedge clk);
            act_valid = 1'b0;
            if (rst && act_req && !m_done && ($urandom_range(0, 99) < valid_pct)) begin
                if (forced_q.size() > 0) begin
                    f = forced_q.pop_front();
                end else begin
                    f.a  = ACT_W'($urandom_range(0, 3));
                    f.ns = ($urandom_range(0, 99) < term_pct) ? 5'd25 : STATE_W'($urandom_range(0, 24));
                end
                act_valid     = 1'b1;
                action_in     = f.a;
                next_state_in = f.ns;
                predictStep(f.a, f.ns);
            end
        end
    end

    // Q-table model: data valid the cycle after the read strobe
    initial begin
        bit                rd_pend;
        logic [ADDR_W-1:0] rd_pend_addr;
        rd_pend = 1'b0;
        rd_pend_addr = '0;
        forever begin
            @(negedge clk);
            q_rd_data    = rd_pend ? mem[rd_pend_addr] : 16'hDEAD;
            rd_pend      = q_rd_en;
            rd_pend_addr = q_rd_addr;
        end
    end

    // Update-ALU model: alu_done alu_delay cycles after alu_start (0 = same cycle)
    initial begin
        int alu_wait;
        alu_wait = 0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            if (alu_wait > 0) begin
                alu_wait--;
                if (alu_wait == 0) alu_done = 1'b1;
            end
            if (rst && alu_start) begin
                alu_starts++;
                if (alu_delay == 0) alu_done = 1'b1;
                else alu_wait = alu_delay;
            end
            if (!rst) begin
                alu_wait = 0;
                alu_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reads or writes the Q-table
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (act_req) act_cycles++;
                if (q_rd_en) begin
                    reads_seen++;
                    if (rd_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_read: got addr %0d, expected no read", q_rd_addr);
                    end else begin
                        checkOutput("rd_addr", q_rd_addr, rd_q.pop_front());
                    end
                end
                if (q_wr_en) begin
                    writes++;
                    seen_max.push_back($signed(max_q));
                    seen_qsa.push_back($signed(q_sa));
                    checkOutput("rd_wr_exclusive", q_rd_en, 0);
                    if (wr_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_write: got addr %0d, expected no write", q_wr_addr);
                    end else begin
                        e = wr_q.pop_front();
                        checkOutput("wr_addr", q_wr_addr, e.addr);
                        checkOutput("wr_q_sa", $signed(q_sa), e.q_sa);
                        checkOutput("wr_max_q", $signed(max_q), e.max_q);
                        checkOutput("wr_step", step, e.step);
                        checkOutput("wr_iteration", iteration, e.iter);
                        checkOutput("wr_latency", cyc - e.accept_cyc, e.lat);
                        checkOutput("alu_start_pulses", alu_starts, 1);
                    end
                    alu_starts = 0;
                end
            end
        end
    end

    initial begin
        int r0, w0, a0;

        // Reset state
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Test 1: reset in the middle of the max-Q reads
        fillMemRandom();
        alu_delay = 1; term_pct = 0; valid_pct = 100;
        r0 = reads_seen;
        applyStimulus(2);
        for (int i = 0; i < 100 && reads_seen < r0 + 3; i++) @(negedge clk);
        checkOutput("t1_reached_rd_max", reads_seen - r0, 3);
        #1 rst = 1'b0;
        #1 checkAllZero("t1_mid_reset");
        m_done = 1'b1;
        rd_q.delete();
        wr_q.delete();
        forced_q.delete();
        alu_starts = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        a0 = act_cycles; w0 = writes;
        repeat (6) @(negedge clk);
        checkOutput("t1_no_act_req_after", act_cycles - a0, 0);
        checkOutput("t1_no_write_after", writes - w0, 0);
        checkOutput("t1_idle_busy", busy, 0);
        checkOutput("t1_idle_done", done, 0);

        // Test 2: memory returns its address, env walks states 1,2,...
        for (int i = 0; i < 128; i++) mem[i] = Q_W'(i);
        for (int i = 0; i < 15; i++) forced_q.push_back('{a: 2'd0, ns: STATE_W'(i + 1)});
        applyStimulus(1);
        waitDone("t2", 2000);
        finalChecks("t2");
        checkOutput("t2_write_count", seen_max.size(), 15);
        checkOutput("t2_first_q_sa", (seen_qsa.size() > 0) ? seen_qsa[0] : -999, 0);
        checkOutput("t2_first_max_q", (seen_max.size() > 0) ? seen_max[0] : -999, 7);
        checkOutput("t2_second_max_q", (seen_max.size() > 1) ? seen_max[1] : -999, 11);

        // Test 3: signed max with a tie, then an all-negative set, then terminal
        fillMemRandom();
        mem[12] = -16'sd5; mem[13] = 16'sd2;  mem[14] = 16'sd2;  mem[15] = -16'sd1;
        mem[16] = -16'sd9; mem[17] = -16'sd3; mem[18] = -16'sd7; mem[19] = -16'sd4;
        forced_q.push_back('{a: 2'd0, ns: 5'd3});
        forced_q.push_back('{a: 2'd1, ns: 5'd4});
        forced_q.push_back('{a: 2'd2, ns: 5'd25});
        valid_pct = 50;
        applyStimulus(1);
        waitDone("t3", 2000);
        finalChecks("t3");
        checkOutput("t3_tie_max_q", (seen_max.size() > 0) ? seen_max[0] : -999, 2);
        checkOutput("t3_negative_max_q", (seen_max.size() > 1) ? seen_max[1] : -999, -3);
        checkOutput("t3_negative_q_sa", (seen_qsa.size() > 2) ? seen_qsa[2] : -999, -7);

        // Test 4: terminal on step 0 ends the run after one write
        fillMemRandom();
        forced_q.push_back('{a: 2'd1, ns: 5'd25});
        applyStimulus(1);
        waitDone("t4", 500);
        finalChecks("t4");
        checkOutput("t4_write_count", seen_max.size(), 1);
        checkOutput("t4_terminal_max_q", (seen_max.size() > 0) ? seen_max[0] : -999, 0);

        // Test 5: never terminal, two full episodes; a start while busy is ignored
        fillMemRandom();
        term_pct = 0; valid_pct = 100; alu_delay = 2;
        w0 = writes;
        applyStimulus(2);
        repeat (40) @(negedge clk);
        total_iteration_in = 12'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("t5", 3000);
        finalChecks("t5");
        checkOutput("t5_write_count", writes - w0, 30);

        // Test 6: zero-episode run, then a slow ALU
        a0 = act_cycles; r0 = reads_seen; w0 = writes;
        applyStimulus(0);
        checkOutput("t6_done_next_cycle", done, 1);
        repeat (5) @(negedge clk);
        checkOutput("t6_no_act_req", act_cycles - a0, 0);
        checkOutput("t6_no_reads", reads_seen - r0, 0);
        checkOutput("t6_no_writes", writes - w0, 0);
        checkOutput("t6_iteration", iteration, 0);
        alu_delay = 10; term_pct = 30;
        applyStimulus(1);
        waitDone("t6_slow_alu", 5000);
        finalChecks("t6_slow_alu");

        // Randomized runs relaunched from DONE
        for (int r = 0; r < 6; r++) begin
            fillMemRandom();
            alu_delay = $urandom_range(0, 3);
            term_pct  = 25;
            valid_pct = 60;
            applyStimulus($urandom_range(1, 3));
            waitDone("rand", 5000);
            finalChecks("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
